pipe_stage_chain: RTL and testbench

- Parametrised chain of STAGES instruction-pipeline registers carrying IR, NPC and TYPE fields, with per-stage valid bits.
- Uses a valid/ready handshake with bubble collapsing, so empty stages are filled even when the output is stalled.
- Per-stage flush kills wrong-path instructions.
- Replaces hand-written IF_ID/ID_EX/EX_MEM/MEM_WB register groups; provides occupancy and retire counters for the pipeline benches.

---
 rtl/pipe_stage_chain.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_chain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a parametrised chain of instruction-pipeline registers
// carrying IR / NPC / TYPE with per-stage valid bits.
//
// Handshake: a transfer happens on a rising edge of clk1 when the sender
// asserts valid and the receiver asserts ready in the same cycle. valid must
// not depend on ready; ready may depend on valid. This holds for both the
// in_* side (in_valid/in_ready) and the out_* side (out_valid/out_ready).
//
// Empty stages always report ready, so bubbles collapse even while the last
// stage is stalled. A set flush_mask bit clears its stage at the edge. The
// flush wins over an incoming item, and the upstream side still sees its
// transfer complete, so the item is dropped and never duplicated.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int TYPE_W = 3,
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic                           clk1,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_ir,
    input  logic [WIDTH-1:0]               in_npc,
    input  logic [TYPE_W-1:0]              in_type,
    input  logic [STAGES-1:0]              flush_mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_ir,
    output logic [WIDTH-1:0]               out_npc,
    output logic [TYPE_W-1:0]              out_type,
    output logic [$clog2(STAGES+1)-1:0]    occupancy,
    output logic [CNT_W-1:0]               retired_count
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  ir_q   [STAGES];
    logic [WIDTH-1:0]  ir_d   [STAGES];
    logic [WIDTH-1:0]  npc_q  [STAGES];
    logic [WIDTH-1:0]  npc_d  [STAGES];
    logic [TYPE_W-1:0] type_q [STAGES];
    logic [TYPE_W-1:0] type_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  ret_q, ret_d;

    // Per-stage sources and the ready chain (rdy[STAGES] is the downstream).
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_ir   [STAGES];
    logic [WIDTH-1:0]  src_npc  [STAGES];
    logic [TYPE_W-1:0] src_type [STAGES];

    // Ready chain, per-stage next state, occupancy and retire counter.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end

        src_v       = '0;
        src_ir      = ir_q;
        src_npc     = npc_q;
        src_type    = type_q;
        src_v[0]    = in_valid;
        src_ir[0]   = in_ir;
        src_npc[0]  = in_npc;
        src_type[0] = in_type;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]    = v_q[k-1];
            src_ir[k]   = ir_q[k-1];
            src_npc[k]  = npc_q[k-1];
            src_type[k] = type_q[k-1];
        end

        v_d    = v_q;
        ir_d   = ir_q;
        npc_d  = npc_q;
        type_d = type_q;
        for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) begin
                // Kill wins over any item arriving this edge.
                v_d[k]    = 1'b0;
                ir_d[k]   = '0;
                npc_d[k]  = '0;
                type_d[k] = '0;
            end else if (src_v[k] && rdy[k]) begin
                v_d[k]    = 1'b1;
                ir_d[k]   = src_ir[k];
                npc_d[k]  = src_npc[k];
                type_d[k] = src_type[k];
            end else if (v_q[k] && rdy[k+1]) begin
                // Item left and nothing replaced it; payload keeps last value.
                v_d[k] = 1'b0;
            end
        end

        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(v_d[k]);
        end

        ret_d = ret_q;
        if (out_valid && out_ready) begin
            ret_d = ret_q + CNT_W'(1);
        end
    end

    // State registers: async reset clears valids, payloads and counters.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
            ret_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ir_q[k]   <= '0;
                npc_q[k]  <= '0;
                type_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            ir_q   <= ir_d;
            npc_q  <= npc_d;
            type_q <= type_d;
            occ_q  <= occ_d;
            ret_q  <= ret_d;
        end
    end

    // A last stage that is being flushed never presents a handshake.
    assign out_valid     = v_q[STAGES-1] & ~flush_mask[STAGES-1];
    assign out_ir        = ir_q[STAGES-1];
    assign out_npc       = npc_q[STAGES-1];
    assign out_type      = type_q[STAGES-1];
    assign in_ready      = rdy[0];
    assign occupancy     = occ_q;
    assign retired_count = ret_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES = 4). Accepted inputs are
// pushed onto an expected queue; a monitor pops and compares on every
// output handshake. Flushed or reset-dropped items are removed from the
// queue by the driver, which knows which stages it kills.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int TYPE_W = 3;
    localparam int STAGES = 4;
    localparam int CNT_W  = 32;
    localparam int OCC_W  = $clog2(STAGES + 1);
    localparam int W      = 2 * WIDTH + TYPE_W;

    logic               clk1 = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_ir = '0;
    logic [WIDTH-1:0]   in_npc = '0;
    logic [TYPE_W-1:0]  in_type = '0;
    logic [STAGES-1:0]  flush_mask = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_ir;
    logic [WIDTH-1:0]   out_npc;
    logic [TYPE_W-1:0]  out_type;
    logic [OCC_W-1:0]   occupancy;
    logic [CNT_W-1:0]   retired_count;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Clock: 10 time units, rising edges at 5, 15, 25, ...
    always #5 clk1 = ~clk1;

    pipe_stage_chain #(
        .WIDTH(WIDTH), .TYPE_W(TYPE_W), .STAGES(STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_npc(in_npc), .in_type(in_type),
        .flush_mask(flush_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_npc(out_npc), .out_type(out_type),
        .occupancy(occupancy), .retired_count(retired_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] ir, input logic [WIDTH-1:0] npc,
                         input logic [TYPE_W-1:0] t);
        in_valid = 1'b1;
        in_ir    = ir;
        in_npc   = npc;
        in_type  = t;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (occupancy != 0 && n < 60) begin
            step();
            n++;
        end
        check(name, W'(occupancy), W'(0));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Scoreboard input side: record every accepted instruction.
    always @(negedge clk1) begin
        if (!reset && in_valid && in_ready) begin
            exp_q.push_back({in_ir, in_npc, in_type});
        end
    end

    // Monitor: compare every output handshake against the oldest expected item.
    always @(negedge clk1) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h expected none at %0t",
                         {out_ir, out_npc, out_type}, $time);
            end else begin
                check("out_payload", {out_ir, out_npc, out_type}, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    logic [WIDTH-1:0] t2_ir [4];
    int lat;

    initial begin
        t2_ir[0] = 32'h28020001;
        t2_ir[1] = 32'h0e94a000;
        t2_ir[2] = 32'h3460fffc;
        t2_ir[3] = 32'h2542fffe;

        // Reset values.
        repeat (2) @(posedge clk1);
        #3 reset = 1'b0;
        step();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_occupancy", W'(occupancy), W'(0));
        check("rst_retired",   W'(retired_count), W'(0));
        check("rst_out_ir",    W'(out_ir),    W'(0));

        // 1: single item latency.
        drive(32'h280a00c8, 32'h4, 3'b000);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("t1_latency", W'(lat), W'(3));
        check("t1_out_ir", W'(out_ir), W'(32'h280a00c8));
        step();
        check("t1_retired", W'(retired_count), W'(1));

        // 2: back-to-back stream, full throughput.
        for (int i = 0; i < 4; i++) begin
            drive(t2_ir[i], 32'(8 + 4 * i), 3'(i + 1));
            #1;
            check("t2_in_ready", W'(in_ready), W'(1));
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_out_valid_run", W'(out_valid), W'(1));
            step();
        end
        check("t2_out_valid_end", W'(out_valid), W'(0));
        check("t2_retired", W'(retired_count), W'(5));

        // 3: stall, fill behind the stalled output, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h30000000 + 32'(i), 32'h100 + 32'(i), 3'(i));
            #1;
            check("t3_in_ready_fill", W'(in_ready), W'(1));
            step();
        end
        drive(32'h30000004, 32'h104, 3'd4);
        #1;
        check("t3_in_ready_full", W'(in_ready), W'(0));
        step();
        check("t3_in_ready_full2", W'(in_ready), W'(0));
        check("t3_occupancy", W'(occupancy), W'(4));
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_release", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        wait_drain("t3_drain");
        check("t3_retired", W'(retired_count), W'(10));

        // 4: flush the two youngest stages of a full chain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h40000000 + 32'(i), 32'h200 + 32'(i), 3'(7 - i));
            step();
        end
        in_valid = 1'b0;
        check("t4_occupancy_full", W'(occupancy), W'(4));
        flush_mask = 4'b0011;
        #1;
        check("t4_in_ready_flush", W'(in_ready), W'(0));
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        step();
        flush_mask = '0;
        check("t4_occupancy_flushed", W'(occupancy), W'(2));
        out_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_retired", W'(retired_count), W'(12));

        // 5: flush the last stage while it is handshaking.
        drive(32'h50000000, 32'h300, 3'b101);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("t5_latency", W'(lat), W'(3));
        flush_mask = 4'b1000;
        #1;
        check("t5_out_valid_flush", W'(out_valid), W'(0));
        void'(exp_q.pop_front());
        step();
        flush_mask = '0;
        check("t5_occupancy", W'(occupancy), W'(0));
        check("t5_retired", W'(retired_count), W'(12));

        // 6: asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(32'h60000000 + 32'(i), 32'h400 + 32'(i), 3'(i));
            step();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("t6_out_valid", W'(out_valid), W'(0));
        check("t6_occupancy", W'(occupancy), W'(0));
        check("t6_retired", W'(retired_count), W'(0));
        check("t6_out_ir", W'(out_ir), W'(0));
        repeat (2) @(posedge clk1);
        #3 reset = 1'b0;
        step();
        drive(32'h6000aaaa, 32'h500, 3'b110);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        check("t6_latency", W'(lat), W'(3));
        check("t6_out_ir_after", W'(out_ir), W'(32'h6000aaaa));
        step();
        check("t6_retired_after", W'(retired_count), W'(1));

        check("final_queue_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
